// File: rtl/score_bcd_conv.sv
// Binary score to four-digit BCD converter for a 7-segment display, using a
// sequential double-dabble. Optional leading-zero blanking: SCORE_BCD_BLANK_EN.
module score_bcd_conv #(
    parameter int SCORE_W  = 16,
    parameter int MAX_DISP = 9999
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [SCORE_W-1:0] in_score,
    output logic [15:0]        digits,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int                 CNT_W   = $clog2(SCORE_W + 1);
    localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_DISP);
`ifdef SCORE_BCD_BLANK_EN
    localparam logic [15:0] DIGITS_RST = 16'hFFF0;
`else
    localparam logic [15:0] DIGITS_RST = 16'h0000;
`endif

    state_t             state;
    logic [SCORE_W-1:0] last_score;
    logic [SCORE_W-1:0] sreg;
    logic [15:0]        acc;
    logic [CNT_W-1:0]   cnt;
    logic [15:0]        acc_adj;

    // Leading zeros become 4'hF (blank); the ones digit is always shown.
    function automatic logic [15:0] present(input logic [15:0] v);
        logic [15:0] r;
        r = v;
`ifdef SCORE_BCD_BLANK_EN
        if (v[15:12] == 4'd0) begin
            r[15:12] = 4'hF;
            if (v[11:8] == 4'd0) begin
                r[11:8] = 4'hF;
                if (v[7:4] == 4'd0) r[7:4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            last_score <= '0;
            sreg       <= '0;
            acc        <= '0;
            cnt        <= '0;
            digits     <= DIGITS_RST;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_score != last_score) begin
                        last_score <= in_score;
                        sreg       <= (in_score > MAX_VAL) ? MAX_VAL : in_score;
                        acc        <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc  <= {acc_adj[14:0], sreg[SCORE_W-1]};
                    sreg <= {sreg[SCORE_W-2:0], 1'b0};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(SCORE_W - 1)) state <= DONE;
                end
                DONE: begin
                    digits <= present(acc);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_score_bcd_conv.sv
// Self-checking bench for score_bcd_conv: table vectors, corner sequences and a
// random sweep checked against an arithmetic decimal model.
module tb_score_bcd_conv;
    localparam int MAX_DISP = 9999;
`ifdef SCORE_BCD_BLANK_EN
    localparam logic [15:0] RST_DIGITS = 16'hFFF0;
    localparam bit          BLANK      = 1'b1;
`else
    localparam logic [15:0] RST_DIGITS = 16'h0000;
    localparam bit          BLANK      = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] in_score = '0;
    logic [15:0] digits;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    score_bcd_conv dut (
        .clk(clk), .clr(clr), .in_score(in_score),
        .digits(digits), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] score;
        logic [15:0] exp_plain;
        logic [15:0] exp_blank;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Decimal digits of the saturated score, built with plain division.
    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        logic [15:0] d;
        s = (v > MAX_DISP) ? MAX_DISP : v;
        d = {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
        if (BLANK) begin
            if (s < 1000) d[15:12] = 4'hF;
            if (s < 100)  d[11:8]  = 4'hF;
            if (s < 10)   d[7:4]   = 4'hF;
        end
        return d;
    endfunction

    function automatic bit nibbles_ok(input logic [15:0] d);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (d[i*4 +: 4] > 4'd9 && !(BLANK && d[i*4 +: 4] == 4'hF)) ok = 1'b0;
        end
        return ok;
    endfunction

    // Input must already be changed; waits for done and checks latency,
    // held digits, final value and single-cycle pulse.
    task automatic wait_done(input string name, input int exp_lat, input logic [15:0] exp);
        logic [15:0] prev;
        int          n;
        bit          seen;
        bit          bad_hold;
        prev = digits;
        n = 0;
        seen = 1'b0;
        bad_hold = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (n == 1) check({name, "_busy_rise"}, busy, 1);
            if (done) seen = 1'b1;
            else if (digits !== prev) bad_hold = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1);
        check({name, "_latency"}, n, exp_lat);
        check({name, "_digits"}, digits, exp);
        check({name, "_nibbles"}, nibbles_ok(digits), 1);
        check({name, "_digits_held"}, bad_hold, 0);
        tick();
        check({name, "_done_width"}, done, 0);
    endtask

    initial begin
        int          act_cnt;
        int          n_done;
        int          t_second;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        busy_at_first;
        bit          any_done;
        logic [15:0] v;

        vecs[0]  = '{16'd1234,  16'h1234, 16'h1234};
        vecs[1]  = '{16'd12345, 16'h9999, 16'h9999};
        vecs[2]  = '{16'd9999,  16'h9999, 16'h9999};
        vecs[3]  = '{16'd10,    16'h0010, 16'hFF10};
        vecs[4]  = '{16'd0,     16'h0000, 16'hFFF0};
        vecs[5]  = '{16'd65535, 16'h9999, 16'h9999};
        vecs[6]  = '{16'd1,     16'h0001, 16'hFFF1};
        vecs[7]  = '{16'd100,   16'h0100, 16'hF100};
        vecs[8]  = '{16'd10000, 16'h9999, 16'h9999};
        vecs[9]  = '{16'd7,     16'h0007, 16'hFFF7};
        vecs[10] = '{16'd1000,  16'h1000, 16'h1000};
        vecs[11] = '{16'd905,   16'h0905, 16'hF905};

        // Reset, then a steady zero input must never start a conversion.
        clr = 1'b1;
        in_score = 16'd0;
        tick();
        tick();
        check("rst_digits", digits, RST_DIGITS);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        clr = 1'b0;
        act_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy || done) act_cnt++;
        end
        check("idle_zero_activity", act_cnt, 0);
        check("idle_zero_digits", digits, RST_DIGITS);

        for (int i = 0; i < 12; i++) begin
            in_score = vecs[i].score;
            wait_done($sformatf("vec%0d", i), 18, BLANK ? vecs[i].exp_blank : vecs[i].exp_plain);
        end

        // Change arrives mid-conversion: ignored, then picked up after one idle cycle.
        in_score = 16'd5;
        wait_done("seq_5", 18, ref_bcd(5));
        in_score = 16'd77;
        n_done = 0;
        t_second = 0;
        d1 = '0;
        d2 = '0;
        busy_at_first = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (t == 5) in_score = 16'd300;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    d1 = digits;
                    busy_at_first = busy;
                end else if (n_done == 2) begin
                    d2 = digits;
                    t_second = t;
                end
            end
        end
        check("seq_done_count", n_done, 2);
        check("seq_first_digits", d1, ref_bcd(77));
        check("seq_idle_gap", busy_at_first, 0);
        check("seq_second_digits", d2, ref_bcd(300));
        check("seq_second_time", t_second, 36);

        // Abort by clr at E8, then reconversion after release.
        in_score = 16'd4321;
        any_done = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (done) any_done = 1'b1;
        end
        clr = 1'b1;
        tick();
        if (done) any_done = 1'b1;
        check("abort_no_done", any_done, 0);
        check("abort_busy", busy, 0);
        check("abort_digits", digits, RST_DIGITS);
        clr = 1'b0;
        wait_done("abort_release", 18, ref_bcd(4321));

        for (int i = 0; i < 25; i++) begin
            v = 16'($urandom_range(0, 65535));
            if (v == in_score) v = v ^ 16'd1;
            in_score = v;
            wait_done($sformatf("rand%0d_%0d", i, v), 18, ref_bcd(int'(v)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
